// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 16x2 character LCD sequencer, 8-bit write-only bus.
// Runs the power-up init, then serves character writes and clears with address-skip.
module lcd_hd44780_ctrl #(
   parameter int unsigned T_PWRUP_CYC = 750000,
   parameter int unsigned T_EN_CYC    = 25,
   parameter int unsigned T_CMD_CYC   = 2500,
   parameter int unsigned T_CLR_CYC   = 82000,
   parameter int unsigned CNT_W       = 20
) (
   input  logic       clock_in,
   input  logic       reset_in,
   input  logic       char_valid_in,
   input  logic [7:0] char_data_in,
   input  logic [4:0] char_pos_in,
   input  logic       clear_in,
   output logic       char_ready_out,
   output logic       init_done_out,
   output logic [7:0] lcd_out,
   output logic       enlcd_out,
   output logic       rslcd_out,
   output logic       rwlcd_out
);

   typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, ADDR, DATA, CLEAR} state_e;
   typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_WAIT} phase_e;

   localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(T_PWRUP_CYC - 1);
   localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(T_EN_CYC - 1);
   localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(T_CMD_CYC - 1);
   localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(T_CLR_CYC - 1);

   state_e           state_q;
   phase_e           phase_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       idx_q;
   logic [7:0]       data_q;
   logic [4:0]       pos_q;
   logic [4:0]       cursor_q;
   logic             cur_valid_q;
   logic             ready_q;
   logic             done_q;
   logic [7:0]       lcd_q;
   logic             en_q;
   logic             rs_q;
   logic [CNT_W-1:0] wait_ld;

   function automatic logic [7:0] init_cmd(input logic [2:0] idx);
      case (idx)
         3'd0, 3'd1, 3'd2: init_cmd = 8'h38;
         3'd3:             init_cmd = 8'h0C;
         3'd4:             init_cmd = 8'h01;
         default:          init_cmd = 8'h06;
      endcase
   endfunction

   // Only the clear command needs the long settle time; a data byte 0x01 does not.
   assign wait_ld = (!rs_q && lcd_q == 8'h01) ? CLR_LD : CMD_LD;

   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) begin
         state_q     <= PWR_WAIT;
         phase_q     <= PH_SETUP;
         cnt_q       <= PWRUP_LD;
         idx_q       <= '0;
         data_q      <= '0;
         pos_q       <= '0;
         cursor_q    <= '0;
         cur_valid_q <= 1'b0;
         ready_q     <= 1'b0;
         done_q      <= 1'b0;
         lcd_q       <= '0;
         en_q        <= 1'b0;
         rs_q        <= 1'b0;
      end else begin
         case (state_q)
            PWR_WAIT: begin
               if (cnt_q == '0) begin
                  state_q <= INIT;
                  phase_q <= PH_SETUP;
                  idx_q   <= '0;
                  lcd_q   <= init_cmd(3'd0);
                  rs_q    <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            IDLE: begin
               phase_q <= PH_SETUP;
               if (clear_in) begin
                  state_q <= CLEAR;
                  lcd_q   <= 8'h01;
                  rs_q    <= 1'b0;
                  ready_q <= 1'b0;
               end else if (char_valid_in) begin
                  data_q  <= char_data_in;
                  pos_q   <= char_pos_in;
                  ready_q <= 1'b0;
                  if (cur_valid_q && cursor_q == char_pos_in) begin
                     state_q <= DATA;
                     lcd_q   <= char_data_in;
                     rs_q    <= 1'b1;
                  end else begin
                     state_q <= ADDR;
                     lcd_q   <= {1'b1, char_pos_in[4], 2'b00, char_pos_in[3:0]};
                     rs_q    <= 1'b0;
                  end
               end
            end
            default: begin
               case (phase_q)
                  PH_SETUP: begin
                     en_q    <= 1'b1;
                     cnt_q   <= EN_LD;
                     phase_q <= PH_PULSE;
                  end
                  PH_PULSE: begin
                     if (cnt_q == '0) begin
                        en_q    <= 1'b0;
                        cnt_q   <= wait_ld;
                        phase_q <= PH_WAIT;
                     end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                     end
                  end
                  default: begin
                     if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                     end else begin
                        phase_q <= PH_SETUP;
                        case (state_q)
                           INIT: begin
                              if (idx_q == 3'd5) begin
                                 done_q      <= 1'b1;
                                 cursor_q    <= '0;
                                 cur_valid_q <= 1'b1;
                                 ready_q     <= 1'b1;
                                 state_q     <= IDLE;
                              end else begin
                                 idx_q <= idx_q + 3'd1;
                                 lcd_q <= init_cmd(idx_q + 3'd1);
                              end
                           end
                           ADDR: begin
                              state_q <= DATA;
                              lcd_q   <= data_q;
                              rs_q    <= 1'b1;
                           end
                           DATA: begin
                              // Past column 15 the DDRAM address leaves the visible window.
                              cursor_q    <= pos_q + 5'd1;
                              cur_valid_q <= (pos_q[3:0] != 4'hF);
                              ready_q     <= 1'b1;
                              state_q     <= IDLE;
                           end
                           default: begin
                              cursor_q    <= '0;
                              cur_valid_q <= 1'b1;
                              ready_q     <= 1'b1;
                              state_q     <= IDLE;
                           end
                        endcase
                     end
                  end
               endcase
            end
         endcase
      end
   end

   assign char_ready_out = ready_q;
   assign init_done_out  = done_q;
   assign lcd_out        = lcd_q;
   assign enlcd_out      = en_q;
   assign rslcd_out      = rs_q;
   assign rwlcd_out      = 1'b0;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Scoreboard bench for lcd_hd44780_ctrl: expected bus transactions are queued by each
// scenario and checked (byte, rs, pulse width, wait length) by a bus monitor.
module tb_lcd_hd44780_ctrl;

   localparam int unsigned TP = 20;
   localparam int unsigned TE = 2;
   localparam int unsigned TC = 5;
   localparam int unsigned TL = 12;

   logic       clock_in = 1'b0;
   logic       reset_in = 1'b0;
   logic       char_valid_in = 1'b0;
   logic [7:0] char_data_in = '0;
   logic [4:0] char_pos_in = '0;
   logic       clear_in = 1'b0;
   logic       char_ready_out, init_done_out, enlcd_out, rslcd_out, rwlcd_out;
   logic [7:0] lcd_out;

   typedef struct {
      logic [7:0]  d;
      logic        rs;
      int unsigned w;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;

   lcd_hd44780_ctrl #(
      .T_PWRUP_CYC(TP),
      .T_EN_CYC   (TE),
      .T_CMD_CYC  (TC),
      .T_CLR_CYC  (TL),
      .CNT_W      (20)
   ) dut (
      .clock_in      (clock_in),
      .reset_in      (reset_in),
      .char_valid_in (char_valid_in),
      .char_data_in  (char_data_in),
      .char_pos_in   (char_pos_in),
      .clear_in      (clear_in),
      .char_ready_out(char_ready_out),
      .init_done_out (init_done_out),
      .lcd_out       (lcd_out),
      .enlcd_out     (enlcd_out),
      .rslcd_out     (rslcd_out),
      .rwlcd_out     (rwlcd_out)
   );

   always #5 clock_in = ~clock_in;
   always @(posedge clock_in) cyc <= cyc + 1;

   // Bus monitor
   logic       en_prev = 1'b0, rdy_prev = 1'b0, pend = 1'b0;
   int         rise_cyc = 0, fall_cyc = 0;
   int unsigned pend_w = 0;
   logic [7:0] rise_d = '0;
   logic       rise_rs = 1'b0;
   exp_t       e;

   always @(negedge clock_in) begin
      if (!reset_in) begin
         en_prev  = 1'b0;
         rdy_prev = 1'b0;
         pend     = 1'b0;
      end else begin
         if (enlcd_out && !en_prev) begin
            rise_cyc = cyc;
            rise_d   = lcd_out;
            rise_rs  = rslcd_out;
            if (pend) begin
               n_checks++;
               if (cyc - fall_cyc - 1 != int'(pend_w)) begin
                  n_fail++;
                  $display("FAIL wait_gap: got %0d cycles, expected %0d", cyc - fall_cyc - 1, pend_w);
               end
               pend = 1'b0;
            end
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_txn: got byte %02h rs %0b, expected no transaction", lcd_out, rslcd_out);
            end
            n_checks++;
            if (rwlcd_out !== 1'b0) begin
               n_fail++;
               $display("FAIL rw: got %0b, expected 0", rwlcd_out);
            end
         end
         if (!enlcd_out && en_prev && sb.size() != 0) begin
            e = sb.pop_front();
            n_checks++;
            if (rise_d !== e.d || rise_rs !== e.rs) begin
               n_fail++;
               $display("FAIL txn_byte: got %02h rs %0b, expected %02h rs %0b", rise_d, rise_rs, e.d, e.rs);
            end
            n_checks++;
            if (lcd_out !== e.d || rslcd_out !== e.rs) begin
               n_fail++;
               $display("FAIL txn_hold: got %02h rs %0b, expected %02h rs %0b", lcd_out, rslcd_out, e.d, e.rs);
            end
            n_checks++;
            if (cyc - rise_cyc != int'(TE)) begin
               n_fail++;
               $display("FAIL en_width: got %0d, expected %0d", cyc - rise_cyc, TE);
            end
            pend     = 1'b1;
            pend_w   = e.w;
            fall_cyc = cyc;
         end
         if (char_ready_out && !rdy_prev && pend) begin
            n_checks++;
            if (cyc - fall_cyc != int'(pend_w)) begin
               n_fail++;
               $display("FAIL last_wait: got %0d cycles, expected %0d", cyc - fall_cyc, pend_w);
            end
            pend = 1'b0;
         end
         en_prev  = enlcd_out;
         rdy_prev = char_ready_out;
      end
   end

   task automatic push_exp(input logic [7:0] d, input logic rs, input int unsigned w);
      exp_t x;
      x.d  = d;
      x.rs = rs;
      x.w  = w;
      sb.push_back(x);
   endtask

   task automatic test_init(input string name);
      int rel, k;
      @(negedge clock_in);
      reset_in = 1'b1;
      rel = cyc;
      push_exp(8'h38, 1'b0, TC);
      push_exp(8'h38, 1'b0, TC);
      push_exp(8'h38, 1'b0, TC);
      push_exp(8'h0C, 1'b0, TC);
      push_exp(8'h01, 1'b0, TL);
      push_exp(8'h06, 1'b0, TC);
      k = 0;
      while (!enlcd_out && k < 100) begin
         @(negedge clock_in);
         k++;
      end
      n_checks++;
      if (cyc - rel != int'(TP + 1)) begin
         n_fail++;
         $display("FAIL %s_pwrup: first enable at %0d, expected %0d", name, cyc - rel, TP + 1);
      end
      k = 0;
      while (!init_done_out && k < 300) begin
         @(negedge clock_in);
         k++;
      end
      n_checks++;
      if (cyc - rel != int'(TP + 6 * (1 + TE) + 5 * TC + TL)) begin
         n_fail++;
         $display("FAIL %s_done_time: got %0d, expected %0d", name, cyc - rel, TP + 6 * (1 + TE) + 5 * TC + TL);
      end
      n_checks++;
      if (init_done_out !== 1'b1 || char_ready_out !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_ready: got done %0b ready %0b, expected 1 1", name, init_done_out, char_ready_out);
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL %s_sb: got %0d pending, expected 0", name, sb.size());
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock_in);
      n_checks++;
      if ({char_ready_out, init_done_out, lcd_out, enlcd_out, rslcd_out, rwlcd_out} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got rdy %0b done %0b lcd %02h en %0b rs %0b rw %0b, expected all 0",
                  char_ready_out, init_done_out, lcd_out, enlcd_out, rslcd_out, rwlcd_out);
      end
      test_init("init");
   endtask

   task automatic test_write(input logic [7:0] d, input logic [4:0] p, input bit skip, input string name);
      int lowc, expc;
      lowc = 0;
      while (!char_ready_out && lowc < 500) begin
         @(negedge clock_in);
         lowc++;
      end
      n_checks++;
      if (char_ready_out !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_ready_timeout: got ready %0b, expected 1", name, char_ready_out);
      end
      if (!skip) push_exp({1'b1, p[4], 2'b00, p[3:0]}, 1'b0, TC);
      push_exp(d, 1'b1, TC);
      char_valid_in = 1'b1;
      char_data_in  = d;
      char_pos_in   = p;
      @(negedge clock_in);
      char_valid_in = 1'b0;
      n_checks++;
      if (char_ready_out !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_ready_drop: got %0b, expected 0", name, char_ready_out);
      end
      lowc = 1;
      while (!char_ready_out && lowc < 200) begin
         @(negedge clock_in);
         if (!char_ready_out) lowc++;
      end
      expc = skip ? int'(1 + TE + TC) : int'(2 * (1 + TE + TC));
      n_checks++;
      if (lowc != expc) begin
         n_fail++;
         $display("FAIL %s_busy_len: got %0d, expected %0d", name, lowc, expc);
      end
      n_checks++;
      if (init_done_out !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_done_held: got %0b, expected 1", name, init_done_out);
      end
   endtask

   task automatic test_clear_priority();
      int lowc;
      push_exp(8'h01, 1'b0, TL);
      clear_in      = 1'b1;
      char_valid_in = 1'b1;
      char_data_in  = 8'h5A;
      char_pos_in   = 5'd7;
      @(negedge clock_in);
      clear_in      = 1'b0;
      char_valid_in = 1'b0;
      lowc = 1;
      while (!char_ready_out && lowc < 200) begin
         @(negedge clock_in);
         if (!char_ready_out) lowc++;
      end
      n_checks++;
      if (lowc != int'(1 + TE + TL)) begin
         n_fail++;
         $display("FAIL clear_busy_len: got %0d, expected %0d", lowc, 1 + TE + TL);
      end
      test_write(8'h5A, 5'd0, 1'b1, "after_clear");
   endtask

   task automatic test_reset_mid_pulse();
      int k;
      push_exp(8'h83, 1'b0, TC);
      char_valid_in = 1'b1;
      char_data_in  = 8'h3F;
      char_pos_in   = 5'd3;
      @(negedge clock_in);
      char_valid_in = 1'b0;
      k = 0;
      while (!enlcd_out && k < 20) begin
         @(negedge clock_in);
         k++;
      end
      reset_in = 1'b0;
      #1;
      n_checks++;
      if ({enlcd_out, lcd_out, init_done_out, char_ready_out, rslcd_out} !== '0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got en %0b lcd %02h done %0b rdy %0b rs %0b, expected all 0",
                  enlcd_out, lcd_out, init_done_out, char_ready_out, rslcd_out);
      end
      sb.delete();
      repeat (3) @(negedge clock_in);
      test_init("reinit");
      test_write(8'h41, 5'd0, 1'b1, "post_reset");
   endtask

   initial begin
      test_reset();
      test_write(8'h41, 5'd5, 1'b0, "write_A");
      test_write(8'h42, 5'd6, 1'b1, "write_B_skip");
      test_write(8'h58, 5'd15, 1'b0, "write_col15");
      test_write(8'h59, 5'd16, 1'b0, "write_row1");
      test_write(8'h5A, 5'd17, 1'b1, "write_row1_skip");
      test_write(8'h61, 5'd31, 1'b0, "write_31");
      test_write(8'h62, 5'd0, 1'b0, "write_after_31");
      test_write(8'h63, 5'd15, 1'b0, "write_col15_again");
      test_write(8'h64, 5'd16, 1'b0, "write_row1_again");
      test_clear_priority();
      test_reset_mid_pulse();
      repeat (10) @(negedge clock_in);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL final_sb: got %0d pending, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
